// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, mode decode and helpers for the multi-channel clock divider
package clk_div_pkg;

  localparam int DIV_W_DEF  = 8;
  localparam int DIV_STOP   = 0;
  localparam int DIV_BYPASS = 1;

  typedef enum logic [1:0] {
    MODE_STOP,
    MODE_BYPASS,
    MODE_DIV
  } div_mode_e;

  function automatic logic [31:0] half(input logic [31:0] n);
    return n >> 1;
  endfunction

  function automatic div_mode_e mode_of(input logic [31:0] n);
    if (n == DIV_STOP) return MODE_STOP;
    if (n == DIV_BYPASS) return MODE_BYPASS;
    return MODE_DIV;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, shadowed divisor, pos/neg phase registers, bypass gate
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] div_n_i,
  input  logic             load_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             running_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             running_q, running_d;
  logic             pos_q, pos_d;
  logic             neg_q, gate_q;
  logic             wrap, sync_go, boundary, apply;

  // Every cycle is a period boundary while stopped or bypassed, so pending divisors land at once.
  always_comb begin
    sync_go   = sync_i && running_q && enable_i;
    wrap      = (count_q == active_q - ONE);
    boundary  = !running_q || (mode_of(32'(active_q)) != MODE_DIV) || wrap || sync_go;
    apply     = pending_q && boundary;
    active_d  = apply ? shadow_q : active_q;
    shadow_d  = load_i ? div_n_i : shadow_q;
    pending_d = load_i || (pending_q && !apply);
    if (boundary) begin
      count_d   = '0;
      running_d = enable_i && (mode_of(32'(active_d)) != MODE_STOP);
    end else begin
      count_d   = count_q + ONE;
      running_d = 1'b1;
    end
    pos_d = running_d && (mode_of(32'(active_d)) == MODE_DIV)
            && (32'(count_d) < half(32'(active_d)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      running_q <= 1'b0;
      pos_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      running_q <= running_d;
      pos_q     <= pos_d;
    end
  end

  // Gate changes only while clk is low, so the bypassed clock never produces a runt.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      neg_q  <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      neg_q  <= pos_q;
      gate_q <= running_q && (mode_of(32'(active_q)) == MODE_BYPASS);
    end
  end

  assign clk_out_o = (clk & gate_q) | pos_q | (active_q[0] & neg_q);
  assign tick_o    = running_q && (count_q == '0);
  assign running_o = running_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider; slices buses into per-channel dividers
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*DIV_W-1:0] div_n,
  input  logic [NUM_CH-1:0]       load,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       pending
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .enable_i (enable[c]),
      .div_n_i  (div_n[c*DIV_W +: DIV_W]),
      .load_i   (load[c]),
      .sync_i   (sync),
      .clk_out_o(clk_out[c]),
      .tick_o   (tick[c]),
      .running_o(running[c]),
      .pending_o(pending[c])
    );
  end

endmodule
